// File: rtl/timer_sched_if.sv
// rtl/timer_sched_if.sv - requester-side bundle for the shared interval timer
interface timer_sched_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic            enable;
    logic [N-1:0]    req;
    logic [N*DW-1:0] len;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            irq;
    logic            busy;
    logic [DW-1:0]   count;

    modport master (
        output enable, req, len,
        input  gnt, done, irq, busy, count
    );

    modport slave (
        input  enable, req, len,
        output gnt, done, irq, busy, count
    );
endinterface

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin shared down-counting interval timer
module timer_sched #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    timer_sched_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [N-1:0]  gnt, gnt_n;
    logic [N-1:0]  done, done_n;
    logic          irq, irq_n;
    logic [DW-1:0] count, count_n;
    logic [IW-1:0] rr_ptr, rr_n;
    logic [IW-1:0] owner, owner_n;

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    // Search starts just after the last owner so a re-requesting owner goes last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!pick_found && bus.req[(int'(rr_ptr) + k) % N]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            done   <= '0;
            irq    <= 1'b0;
            count  <= '0;
            rr_ptr <= IW'(N - 1);
            owner  <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            done   <= done_n;
            irq    <= irq_n;
            count  <= count_n;
            rr_ptr <= rr_n;
            owner  <= owner_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        done_n  = '0;
        irq_n   = 1'b0;
        count_n = count;
        rr_n    = rr_ptr;
        owner_n = owner;
        case (state)
            IDLE: begin
                gnt_n   = '0;
                count_n = '0;
                if (pick_found) begin
                    state_n = RUN;
                    gnt_n   = N'(1) << pick_idx;
                    count_n = bus.len[int'(pick_idx) * DW +: DW];
                    rr_n    = pick_idx;
                    owner_n = pick_idx;
                end
            end
            RUN: begin
                // Abort wins over expiry; a zero length expires like a length of one.
                if (!bus.req[owner]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    count_n = '0;
                end else if (bus.enable) begin
                    if (count <= DW'(1)) begin
                        state_n = DONE;
                        count_n = '0;
                        done_n  = gnt;
                        irq_n   = 1'b1;
                    end else begin
                        count_n = count - DW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                count_n = '0;
            end
        endcase
    end

    assign bus.gnt   = gnt;
    assign bus.done  = done;
    assign bus.irq   = irq;
    assign bus.count = count;
    assign bus.busy  = (state == RUN) || (state == DONE);
endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed self-checking bench for timer_sched
module tb_timer_sched;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    timer_sched_if #(.N(N), .DW(DW)) bus ();

    timer_sched #(.N(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [7:0] c,
                              input logic [3:0] d, input logic b);
        check({tag, ".gnt"},   32'(bus.gnt),   32'(g));
        check({tag, ".count"}, 32'(bus.count), 32'(c));
        check({tag, ".done"},  32'(bus.done),  32'(d));
        check({tag, ".irq"},   32'(bus.irq),   32'(|d));
        check({tag, ".busy"},  32'(bus.busy),  32'(b));
    endtask

    task automatic set_len(input int i, input logic [7:0] v);
        bus.len[i*DW +: DW] = v;
    endtask

    initial begin
        logic [3:0] oh;
        bus.enable = 1'b1;
        bus.req    = '0;
        bus.len    = '0;
        #2 rst = 1'b1;

        // reset state
        @(negedge clk);
        expect_out("reset", 4'b0000, 8'd0, 4'b0000, 1'b0);
        rst = 1'b0;

        // 1: single request, len 5
        bus.req = 4'b0001;
        set_len(0, 8'd5);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            expect_out($sformatf("t1.c%0d", c), 4'b0001, (c < 5) ? 8'(5 - c) : 8'd0,
                       (c == 5) ? 4'b0001 : 4'b0000, 1'b1);
            if (c == 5) bus.req = 4'b0000;
        end
        @(negedge clk);
        expect_out("t1.idle", 4'b0000, 8'd0, 4'b0000, 1'b0);

        // 2: enable low for 3 cycles mid-RUN
        bus.req = 4'b0001;
        @(negedge clk);
        expect_out("t2.grant", 4'b0001, 8'd5, 4'b0000, 1'b1);
        @(negedge clk);
        expect_out("t2.c4", 4'b0001, 8'd4, 4'b0000, 1'b1);
        bus.enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            expect_out($sformatf("t2.hold%0d", c), 4'b0001, 8'd4, 4'b0000, 1'b1);
        end
        bus.enable = 1'b1;
        for (int c = 3; c >= 1; c--) begin
            @(negedge clk);
            expect_out($sformatf("t2.c%0d", c), 4'b0001, 8'(c), 4'b0000, 1'b1);
        end
        @(negedge clk);
        expect_out("t2.done", 4'b0001, 8'd0, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("t2.idle", 4'b0000, 8'd0, 4'b0000, 1'b0);

        // 3: all request, len 2, round-robin from fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_len(i, 8'd2);
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            oh = 4'(1 << i);
            @(negedge clk);
            expect_out($sformatf("t3.r%0d.c2", i), oh, 8'd2, 4'b0000, 1'b1);
            @(negedge clk);
            expect_out($sformatf("t3.r%0d.c1", i), oh, 8'd1, 4'b0000, 1'b1);
            @(negedge clk);
            expect_out($sformatf("t3.r%0d.done", i), oh, 8'd0, oh, 1'b1);
            bus.req[i] = 1'b0;
            @(negedge clk);
            expect_out($sformatf("t3.r%0d.idle", i), 4'b0000, 8'd0, 4'b0000, 1'b0);
        end

        // 4: abort requester 1 after 4 RUN cycles, then requester 0 runs normally
        bus.req = 4'b0010;
        set_len(1, 8'd10);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            expect_out($sformatf("t4.c%0d", 10 - c), 4'b0010, 8'(10 - c), 4'b0000, 1'b1);
        end
        bus.req = 4'b0001;
        set_len(0, 8'd3);
        @(negedge clk);
        expect_out("t4.abort", 4'b0000, 8'd0, 4'b0000, 1'b0);
        for (int c = 3; c >= 1; c--) begin
            @(negedge clk);
            expect_out($sformatf("t4.r0.c%0d", c), 4'b0001, 8'(c), 4'b0000, 1'b1);
        end
        @(negedge clk);
        expect_out("t4.r0.done", 4'b0001, 8'd0, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("t4.idle", 4'b0000, 8'd0, 4'b0000, 1'b0);

        // 5: len 0 behaves as len 1
        bus.req = 4'b0100;
        set_len(2, 8'd0);
        @(negedge clk);
        expect_out("t5.run", 4'b0100, 8'd0, 4'b0000, 1'b1);
        @(negedge clk);
        expect_out("t5.done", 4'b0100, 8'd0, 4'b0100, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("t5.idle", 4'b0000, 8'd0, 4'b0000, 1'b0);

        // 6: asynchronous reset mid-RUN, then requester 0 wins first
        bus.req = 4'b0001;
        set_len(0, 8'd5);
        @(negedge clk);
        expect_out("t6.grant", 4'b0001, 8'd5, 4'b0000, 1'b1);
        @(negedge clk);
        expect_out("t6.c4", 4'b0001, 8'd4, 4'b0000, 1'b1);
        #2 rst = 1'b1;
        #1 expect_out("t6.async", 4'b0000, 8'd0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_len(i, 8'd2);
        bus.req = 4'b1111;
        @(negedge clk);
        expect_out("t6.first", 4'b0001, 8'd2, 4'b0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
